// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
// Groups the host byte stream, the instruction-memory write port and the
// CPU control/status lines of the instruction-memory loader.
//   in_data/in_valid   host -> loader stream byte and qualifier
//   in_ready           loader -> host, byte transfers when valid && ready
//   mem_we/addr/data   loader -> instruction memory write port
//   cpu_hold           loader -> CPU, holds CPU in reset while high
//   load_done          one-cycle pulse on a verified frame
//   load_error         sticky checksum-failure flag
// modport master: host/system side.  modport slave: the loader itself.
// ---------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  cpu_hold;
  logic                  load_done;
  logic                  load_error;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_data, cpu_hold, load_done, load_error
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_data, cpu_hold, load_done, load_error
  );
endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Parses a framed byte stream (header, length, start address, payload,
// checksum) and writes each payload byte into the instruction memory. The
// CPU is held in reset from the header until a frame's checksum verifies.
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-low
//   bus    imem_loader_if.slave (stream in, memory write port, CPU control)
// Length byte 0 means 256 words; address and checksum wrap modulo 256.
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int         ADDR_WIDTH = 8,
  parameter int         DATA_WIDTH = 8,
  parameter logic [7:0] HEADER     = 8'hA5
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_ADDR,
    S_DATA,
    S_CHK,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;      // next payload write address
  logic [8:0]            remain_q, remain_d;  // 9 bits so N = 256 fits
  logic [7:0]            sum_q, sum_d;        // running payload checksum
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  hold_q, hold_d;
  logic                  err_q, err_d;

  logic in_ready;
  logic accept;

  // The DONE cycle is the only one in which the loader refuses a byte.
  assign in_ready = (state_q != S_DONE);
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready   = in_ready;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = waddr_q;
  assign bus.mem_data   = wdata_q;
  assign bus.cpu_hold   = hold_q;
  assign bus.load_done  = (state_q == S_DONE);
  assign bus.load_error = err_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      sum_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      hold_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      sum_q    <= sum_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      hold_q   <= hold_d;
      err_q    <= err_d;
    end
  end

  // NOTE: every signal gets a default before the case statement, so no path
  // through the logic leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    sum_d    = sum_q;
    we_d     = 1'b0;          // write strobe lasts exactly one cycle
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    hold_d   = hold_q;
    err_d    = err_q;

    unique case (state_q)
      S_IDLE: begin
        // Non-header bytes are dropped here; this is the only resync point.
        if (accept && bus.in_data == HEADER) begin
          state_d = S_LEN;
          hold_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      S_LEN: begin
        if (accept) begin
          remain_d = (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (accept) begin
          addr_d  = ADDR_WIDTH'(bus.in_data);
          sum_d   = 8'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          we_d     = 1'b1;
          waddr_d  = addr_q;
          wdata_d  = DATA_WIDTH'(bus.in_data);
          addr_d   = addr_q + ADDR_WIDTH'(1);
          sum_d    = sum_q + bus.in_data;
          remain_d = remain_q - 9'd1;
          if (remain_q == 9'd1) begin
            state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (accept) begin
          if (bus.in_data == sum_q) begin
            state_d = S_DONE;
            hold_d  = 1'b0;   // releases the CPU together with load_done
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;   // CPU stays held; written words are kept
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Frame-level reference model: each frame's expected memory writes and its
// outcome (done or error) are derived from the payload with plain arithmetic
// and queued with the time they must appear. A monitor running on the
// falling clock edge pops and compares whatever the DUT presents.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam int HALF = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #HALF clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  imem_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .HEADER(8'hA5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    time        t;
  } wr_t;

  typedef enum int {EV_HOLD = 1, EV_CLR = 2, EV_ERR = 3, EV_DONE = 4} ev_e;

  typedef struct {
    ev_e kind;
    time t;
  } ev_t;

  wr_t        exp_wr[$];
  ev_t        exp_ev[$];
  logic [7:0] pl[$];
  int         n_vec  = 0;
  int         n_fail = 0;
  bit         hold_m = 1'b1;
  bit         err_m  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   32'(bus.in_ready),   32'd1);
    check({tag, "_mem_we"},     32'(bus.mem_we),     32'd0);
    check({tag, "_mem_addr"},   32'(bus.mem_addr),   32'd0);
    check({tag, "_mem_data"},   32'(bus.mem_data),   32'd0);
    check({tag, "_cpu_hold"},   32'(bus.cpu_hold),   32'd1);
    check({tag, "_load_done"},  32'(bus.load_done),  32'd0);
    check({tag, "_load_error"}, 32'(bus.load_error), 32'd0);
  endtask

  // Presents one byte and returns the time of the edge that transferred it.
  task automatic send_byte(input logic [7:0] b, input bit gap, output time t_acc);
    int n;
    if (gap) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_transfer", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    t_acc = $time;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_garbage(input int n);
    time        t;
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      send_byte(b, 1'b0, t);
    end
  endtask

  task automatic send_header(input bit gap);
    time t;
    send_byte(8'hA5, gap, t);
    if (!hold_m) exp_ev.push_back('{EV_HOLD, t + HALF});
    if (err_m)   exp_ev.push_back('{EV_CLR,  t + HALF});
    hold_m = 1'b1;
    err_m  = 1'b0;
  endtask

  // Sends header, length, address, the payload held in pl[] and a checksum
  // (deliberately off by one bit when corrupt is set).
  task automatic send_frame(input logic [7:0] addr, input bit corrupt, input bit gap);
    time        t;
    logic [7:0] sum;
    int         n;
    n = pl.size();
    send_header(gap);
    send_byte(8'(n), gap, t);
    send_byte(addr, gap, t);
    sum = 8'd0;
    for (int i = 0; i < n; i++) begin
      send_byte(pl[i], gap, t);
      exp_wr.push_back('{8'(int'(addr) + i), pl[i], t + HALF});
      sum = sum + pl[i];
    end
    send_byte(sum ^ {7'd0, corrupt}, gap, t);
    if (corrupt) begin
      exp_ev.push_back('{EV_ERR, t + HALF});
      err_m = 1'b1;
    end else begin
      exp_ev.push_back('{EV_DONE, t + HALF});
      hold_m = 1'b0;
    end
  endtask

  task automatic random_payload(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
  endtask

  task automatic expect_ev(input ev_e k);
    ev_t e;
    if (exp_ev.size() == 0) begin
      check("unexpected_event_kind", 32'(k), 32'd0);
    end else begin
      e = exp_ev.pop_front();
      check("event_kind", 32'(k), 32'(e.kind));
      check("event_time", 32'($time), 32'(e.t));
    end
  endtask

  // Monitor / scoreboard
  initial begin
    logic prev_hold;
    logic prev_err;
    wr_t  w;
    prev_hold = 1'b1;
    prev_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_hold = 1'b1;
        prev_err  = 1'b0;
      end else begin
        while (exp_wr.size() > 0 && exp_wr[0].t < $time) begin
          w = exp_wr.pop_front();
          check("missed_write_time", 32'($time), 32'(w.t));
        end
        while (exp_ev.size() > 0 && exp_ev[0].t < $time) begin
          check("missed_event_time", 32'($time), 32'(exp_ev[0].t));
          void'(exp_ev.pop_front());
        end
        if (bus.mem_we) begin
          if (exp_wr.size() == 0) begin
            check("unexpected_write", 32'(bus.mem_we), 32'd0);
          end else begin
            w = exp_wr.pop_front();
            check("write_addr", 32'(bus.mem_addr), 32'(w.addr));
            check("write_data", 32'(bus.mem_data), 32'(w.data));
            check("write_time", 32'($time), 32'(w.t));
          end
        end
        if (bus.cpu_hold && !prev_hold)   expect_ev(EV_HOLD);
        if (!bus.load_error && prev_err)  expect_ev(EV_CLR);
        if (bus.load_error && !prev_err)  expect_ev(EV_ERR);
        if (bus.load_done) begin
          expect_ev(EV_DONE);
          check("done_cpu_hold", 32'(bus.cpu_hold), 32'd0);
          check("done_in_ready", 32'(bus.in_ready), 32'd0);
        end
        if (!bus.cpu_hold && prev_hold) check("hold_fall_with_done", 32'(bus.load_done), 32'd1);
        prev_hold = bus.cpu_hold;
        prev_err  = bus.load_error;
      end
    end
  end

  // Stimulus
  initial begin
    time t;
    bus.in_data  = 8'd0;
    bus.in_valid = 1'b0;
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    // Reference frame, then the same frame with a bad checksum, then recovery.
    pl = '{8'hA2, 8'hAB, 8'h08};
    send_frame(8'h00, 1'b0, 1'b0);
    idle(3);
    send_frame(8'h00, 1'b1, 1'b0);
    idle(3);
    random_payload(5);
    send_frame(8'h40, 1'b0, 1'b0);
    idle(2);

    // Junk before a header is discarded.
    send_byte(8'h00, 1'b0, t);
    send_byte(8'hFF, 1'b0, t);
    random_payload(4);
    send_frame(8'h10, 1'b0, 1'b0);
    idle(2);

    // Full 256-word frame wrapping from F0 through FF to EF.
    pl.delete();
    for (int i = 0; i < 256; i++) pl.push_back(8'(i));
    send_frame(8'hF0, 1'b0, 1'b0);
    idle(2);

    // in_valid toggling every cycle.
    pl = '{8'hA2, 8'hAB, 8'h08};
    send_frame(8'h00, 1'b0, 1'b1);
    idle(2);

    // Randomized frames: lengths, wrap-prone addresses, gaps, bad checksums.
    for (int k = 0; k < 12; k++) begin
      random_payload(int'($urandom_range(1, 12)));
      if ($urandom_range(0, 2) == 0) send_garbage(int'($urandom_range(1, 3)));
      send_frame((k % 2 == 0) ? 8'(8'hF8 + $urandom_range(0, 7)) : 8'($urandom),
                 ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 4)));
    end
    random_payload(3);
    send_frame(8'h20, 1'b0, 1'b0);
    idle(2);

    // Reset after two of three payload bytes.
    send_header(1'b0);
    send_byte(8'h03, 1'b0, t);
    send_byte(8'h00, 1'b0, t);
    send_byte(8'h11, 1'b0, t);
    exp_wr.push_back('{8'h00, 8'h11, t + HALF});
    send_byte(8'h22, 1'b0, t);
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    exp_wr.delete();
    exp_ev.delete();
    hold_m = 1'b1;
    err_m  = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    // The leftover third payload byte must be treated as junk in IDLE.
    send_byte(8'h33, 1'b0, t);
    pl = '{8'h5C, 8'h01, 8'hE7};
    send_frame(8'h00, 1'b0, 1'b0);
    idle(6);

    check("pending_writes",   32'(exp_wr.size()),    32'd0);
    check("pending_events",   32'(exp_ev.size()),    32'd0);
    check("final_cpu_hold",   32'(bus.cpu_hold),     32'(hold_m));
    check("final_load_error", 32'(bus.load_error),   32'(err_m));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream programmer that writes the 256 x 8 instruction memory from an external host before the CPU runs. It parses a framed stream: header, length, start address, payload, checksum. It drives the memory's write port one instruction per accepted payload byte and holds the CPU in reset until a frame's checksum verifies. It is the writer side of the instruction memory, which the CPU only reads.

## Interface
- `ADDR_WIDTH`, 8: instruction memory address width; memory depth 2^ADDR_WIDTH.
- `DATA_WIDTH`, 8: instruction width.
- `HEADER`, 8'hA5: frame start byte.

- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately on assertion.
- `in_data`  in  8  stream byte from host.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader can accept; a byte transfers on a rising edge with `in_valid && in_ready`.
- `mem_we`  out  1  instruction memory write enable, one cycle per word.
- `mem_addr`  out  ADDR_WIDTH  write address.
- `mem_data`  out  DATA_WIDTH  write data.
- `cpu_hold`  out  1  holds the CPU in reset while high.
- `load_done`  out  1  one-cycle pulse on a verified frame.
- `load_error`  out  1  sticky checksum-failure flag.

## Operation
- States: IDLE, LEN, ADDR, DATA, CHK, DONE.
- IDLE: accepted byte == `HEADER` -> LEN; clears `load_error` and asserts `cpu_hold`. Any other byte is discarded and the state stays IDLE.
- LEN: accepted byte is the word count N; N = 0 means 256. Go to ADDR.
- ADDR: accepted byte loads the address counter; clear the running sum to 0. Go to DATA.
- DATA: each accepted byte is written at the address counter. Address +1 mod 256, so 8'hFF wraps to 8'h00. Sum += byte mod 256. Remaining count -1. After the Nth byte go to CHK.
- CHK: accepted byte == sum -> DONE. Otherwise set `load_error` and go to IDLE; `cpu_hold` stays high.
- DONE: one cycle. `load_done` = 1, `cpu_hold` -> 0, `in_ready` = 0. Then IDLE.
- After a good load, a new `HEADER` re-asserts `cpu_hold` and reloads. Words already written by a failed frame are not rolled back.
- A header byte seen in LEN, ADDR, DATA or CHK is ordinary data; there is no resync mid-frame.

## Timing
- Reset values: `in_ready` 1, `mem_we` 0, `mem_addr` 0, `mem_data` 0, `cpu_hold` 1, `load_done` 0, `load_error` 0, state IDLE.
- `in_ready` is 1 in every state except DONE. Back-to-back bytes are accepted every cycle.
- Write latency: `mem_we`, `mem_addr` and `mem_data` are registered and asserted the cycle after the payload byte is accepted, for exactly one cycle. Memory samples them on the next edge.
- `cpu_hold` falls in the same cycle `load_done` is high, which is 1 cycle after the checksum byte is accepted. The last data write precedes it by at least 1 cycle.
- `cpu_hold` rises the cycle after the header is accepted.
- `load_error` rises the cycle after a bad checksum is accepted and holds until the next accepted header.
- `in_valid` low in any state: no state change, counters hold.
- Reset mid-frame: state returns to IDLE and `cpu_hold` returns to 1 asynchronously. Any pending `mem_we` is dropped the same instant.
- Counters: the address counter is ADDR_WIDTH bits and wraps. The remaining-count counter is 9 bits so N = 256 is representable. The sum is 8 bits and wraps.

## Test plan
- Stream A5,03,00,A2,AB,08,55 -> memory writes [0]=A2, [1]=AB, [2]=08 on consecutive cycles; `load_done` pulses; `cpu_hold` 0; `load_error` 0.
- Same frame with checksum 54 -> all three words written; `load_error` 1; `cpu_hold` stays 1; no `load_done`. A following good frame clears `load_error`.
- Stream 00,FF,A5 then a valid frame -> 00 and FF are discarded with no `mem_we`; the frame loads normally.
- Frame A5,00,F0 with 256 payload bytes, each byte = its index, and checksum 80 -> writes [F0..FF] then wrap to [00..EF]; exactly 256 `mem_we` pulses; `load_done` pulses.
- Frame with `in_valid` toggled 1/0 every cycle -> same writes as the back-to-back case, each write 1 cycle after its byte is accepted; no duplicate writes.
- Reset asserted after 2 of 3 payload bytes -> all outputs return to reset values immediately. After release, a partial frame's leftovers are not resumed, and a fresh frame loads correctly.
